decode_writeback: RTL and testbench
===================================

Name: decode_writeback

Overview:
- Register-file stage of the SEQ Y86-64 core, directly upstream of the execute stage.
- Decode half:
  - selects source registers from icode/rA/rB;
  - drives valA/valB combinationally into execute.
- Write-back half:
  - commits valE (from execute) and valM (from memory) into the 15-entry register file on the rising clock edge;
  - uses Cnd for conditional moves.
- Tracks processor halt so no state changes after a halt instruction.

Parameters:
- NREGS, 15, number of architectural registers (IDs 0..14; ID 15 = RNONE).
- WIDTH, 64, data width of registers and values.
- RSP_ID, 4, register ID of the stack pointer.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- icode  input  4  current instruction code
- rA  input  4  register specifier A
- rB  input  4  register specifier B
- Cnd  input  1  condition result from execute (cmov gating)
- valE  input  64  ALU result from execute
- valM  input  64  load data from memory stage
- valA  output  64  source-A operand to execute
- valB  output  64  source-B operand to execute
- halted  output  1  set once halt (icode 0) retires
- inv_instr  output  1  combinational flag: icode > 11

Behaviour:
- Reset: one clock with rst=1 clears all 15 registers to 0 and clears halted. Reset mid-operation discards any write pending in that cycle.
- srcA:
  - icode 2,4,6,10 -> rA
  - icode 9,11 -> RSP_ID
  - otherwise RNONE
- srcB:
  - icode 4,5,6 -> rB
  - icode 8,9,10,11 -> RSP_ID
  - otherwise RNONE
- dstE:
  - icode 2 -> rB if Cnd=1, else RNONE
  - icode 3,6 -> rB
  - icode 8,9,10,11 -> RSP_ID
  - otherwise RNONE
- dstM: icode 5,11 -> rA; otherwise RNONE.
- Reads:
  - valA = R[srcA], valB = R[srcB], combinational, zero latency.
  - A source of RNONE (or any ID >= NREGS) reads 64'h0.
- Writes:
  - On posedge with rst=0 and halted=0: R[dstE] <= valE, R[dstM] <= valM.
  - A destination of RNONE performs no write.
  - dstE == dstM (e.g. popq %rsp): valM wins, valE discarded.
- Halt:
  - icode 0 on a posedge with rst=0 sets halted=1; the halt cycle itself performs no writes.
  - halted is sticky until rst; while halted=1 all register writes are suppressed and reads remain valid.
- Invalid instruction:
  - inv_instr=1 when icode > 11.
  - Register writes are suppressed in that cycle; halted is not set by this block.
- Write-then-read ordering: a value written at edge N is visible on valA/valB after edge N (no same-cycle forwarding by default).

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: read ports forward same-cycle write data.
  - If srcA/srcB equals the active dstM, the read returns valM.
  - Otherwise, if it equals the active dstE, the read returns valE.
  - No forwarding while halted or in reset.
- Undefined: reads always return stored register contents.

Decomposition:
- Shared package y86_pkg:
  - icode constants (IHALT=0, INOP=1, IRRMOVQ=2, IIRMOVQ=3, IRMMOVQ=4, IMRMOVQ=5, IOPQ=6, IJXX=7, ICALL=8, IRET=9, IPUSHQ=10, IPOPQ=11);
  - RNONE=4'hF and RRSP=4'h4;
  - a 4-bit reg_id typedef.
- One sub-module, reg_file: 2 combinational read ports, 2 synchronous write ports with M-priority and the optional bypass.
- Register-ID selection logic stays in decode_writeback.

Test Plan:
1. rst=1 one cycle, then icode=6, rA=0, rB=3 -> valA=0, valB=0, halted=0.
2. icode=3 (irmovq), rB=2, valE=64'h1234 edge; then icode=6, rA=2 -> valA=64'h1234.
3. icode=2 (cmov), rA=1, rB=5, valE=64'hAA:
   - Cnd=0 edge -> R5 unchanged (0);
   - Cnd=1 edge -> R5=64'hAA.
4. icode=11 (popq), rA=4, valE=64'h108, valM=64'h55 edge -> R4=64'h55 (valM priority); icode=9 next -> valA=valB=64'h55.
5. icode=0 edge -> halted=1; then icode=3, rB=7, valE=64'h9 edge -> R7 stays 0; rst edge -> halted=0.
6. icode=12, rB=1 -> inv_instr=1, no write to any register. With WB_BYPASS_EN: icode=6, rA=rB=6, valE=64'h77 -> valA=valB=64'h77 before the edge.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs and the
// register-ID type used by the decode / write-back stage.
package y86_pkg;

  // 4-bit architectural register identifier (15 = no register)
  typedef logic [3:0] reg_id;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Special register IDs
  localparam reg_id RNONE = 4'hF;
  localparam reg_id RRSP  = 4'h4;

endpackage

// File: rtl/decode_writeback_reg_file.sv
// Register file: two combinational read ports, two synchronous write ports.
// When both write ports target the same register the M port wins.
// Optional macro WB_BYPASS_EN: read ports forward the data being written in
// the same cycle (M data preferred over E data).
module reg_file
  import y86_pkg::*;
#(
  parameter int NREGS = 15,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  reg_id            srcA,
  input  reg_id            srcB,
  input  reg_id            dstE,
  input  reg_id            dstM,
  input  logic [WIDTH-1:0] valE,
  input  logic [WIDTH-1:0] valM,
  output logic [WIDTH-1:0] valA,
  output logic [WIDTH-1:0] valB
);

  logic [WIDTH-1:0] regs [NREGS];

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : gReg
      logic [WIDTH-1:0] q;
      // One storage word per register; M port has priority over E port
      always_ff @(posedge clk) begin
        if (rst) begin
          q <= '0;
        end else if (we && dstM == reg_id'(gi)) begin
          q <= valM;
        end else if (we && dstE == reg_id'(gi)) begin
          q <= valE;
        end
      end
      assign regs[gi] = q;
    end
  endgenerate

  // IDs outside the register file (including RNONE) read as zero
  function automatic logic [WIDTH-1:0] readReg(input reg_id src);
    logic [WIDTH-1:0] r;
    r = '0;
    if (int'(src) < NREGS) begin
      r = regs[src];
    end
`ifdef WB_BYPASS_EN
    if (we && src == dstM && int'(dstM) < NREGS) begin
      r = valM;
    end else if (we && src == dstE && int'(dstE) < NREGS) begin
      r = valE;
    end
`endif
    return r;
  endfunction

  // Combinational read ports
  always_comb begin
    valA = readReg(srcA);
    valB = readReg(srcB);
  end

endmodule

// File: rtl/decode_writeback.sv
// SEQ Y86-64 decode / write-back stage: picks source and destination
// register IDs from the instruction, reads operands for execute and commits
// execute/memory results. Halt is sticky until reset.
// Optional macro WB_BYPASS_EN enables same-cycle write-to-read forwarding.
module decode_writeback
  import y86_pkg::*;
#(
  parameter int    NREGS  = 15,
  parameter int    WIDTH  = 64,
  parameter reg_id RSP_ID = RRSP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       icode,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic             Cnd,
  input  logic [WIDTH-1:0] valE,
  input  logic [WIDTH-1:0] valM,
  output logic [WIDTH-1:0] valA,
  output logic [WIDTH-1:0] valB,
  output logic             halted,
  output logic             inv_instr
);

  reg_id srcA, srcB, dstE, dstM;
  logic  haltedReg;
  logic  writeEn;

  // Register-ID selection per instruction class
  always_comb begin
    srcA = RNONE;
    srcB = RNONE;
    dstE = RNONE;
    dstM = RNONE;
    case (icode)
      IRRMOVQ: begin srcA = rA; if (Cnd) dstE = rB; end
      IIRMOVQ: begin dstE = rB; end
      IRMMOVQ: begin srcA = rA; srcB = rB; end
      IMRMOVQ: begin srcB = rB; dstM = rA; end
      IOPQ:    begin srcA = rA; srcB = rB; dstE = rB; end
      ICALL:   begin srcB = RSP_ID; dstE = RSP_ID; end
      IRET:    begin srcA = RSP_ID; srcB = RSP_ID; dstE = RSP_ID; end
      IPUSHQ:  begin srcA = rA; srcB = RSP_ID; dstE = RSP_ID; end
      IPOPQ:   begin srcA = RSP_ID; srcB = RSP_ID; dstE = RSP_ID; dstM = rA; end
      default: ;
    endcase
  end

  assign inv_instr = (icode > IPOPQ);

  // Writes only for valid, non-halt instructions while running
  assign writeEn = !rst && !haltedReg && (icode != IHALT) && !inv_instr;

  // Sticky halt flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      haltedReg <= 1'b0;
    end else if (icode == IHALT) begin
      haltedReg <= 1'b1;
    end
  end

  assign halted = haltedReg;

  reg_file #(
    .NREGS(NREGS),
    .WIDTH(WIDTH)
  ) uRegFile (
    .clk  (clk),
    .rst  (rst),
    .we   (writeEn),
    .srcA (srcA),
    .srcB (srcB),
    .dstE (dstE),
    .dstM (dstM),
    .valE (valE),
    .valM (valM),
    .valA (valA),
    .valB (valB)
  );

endmodule

// File: tb/tb_decode_writeback.sv
// Self-checking bench for decode_writeback: directed scenarios plus random
// instruction streams compared against a behavioural register-file model.
module tb_decode_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  icode, rA, rB;
  logic        Cnd;
  logic [63:0] valE, valM, valA, valB;
  logic        halted, inv_instr;

  int checks = 0;
  int failures = 0;

  logic [63:0] model [15];
  bit          mHalted;

  always #5 clk = ~clk;

  decode_writeback dut (
    .clk       (clk),
    .rst       (rst),
    .icode     (icode),
    .rA        (rA),
    .rB        (rB),
    .Cnd       (Cnd),
    .valE      (valE),
    .valM      (valM),
    .valA      (valA),
    .valB      (valB),
    .halted    (halted),
    .inv_instr (inv_instr)
  );

  function automatic logic [3:0] expSrcA(input logic [3:0] ic, input logic [3:0] a);
    if (ic inside {4'd2, 4'd4, 4'd6, 4'd10}) return a;
    if (ic inside {4'd9, 4'd11}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] expSrcB(input logic [3:0] ic, input logic [3:0] b);
    if (ic inside {4'd4, 4'd5, 4'd6}) return b;
    if (ic inside {4'd8, 4'd9, 4'd10, 4'd11}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] expDstE(input logic [3:0] ic, input logic [3:0] b, input logic c);
    if (ic == 4'd2) return c ? b : 4'hF;
    if (ic inside {4'd3, 4'd6}) return b;
    if (ic inside {4'd8, 4'd9, 4'd10, 4'd11}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] expDstM(input logic [3:0] ic, input logic [3:0] a);
    if (ic inside {4'd5, 4'd11}) return a;
    return 4'hF;
  endfunction

  // Expected read value for one source under the current model state
  function automatic logic [63:0] expRead(input logic [3:0] src, input bit active,
                                          input logic [3:0] dE, input logic [3:0] dM,
                                          input logic [63:0] e, input logic [63:0] m);
    logic [63:0] r;
    r = (src < 4'd15) ? model[src] : 64'h0;
`ifdef WB_BYPASS_EN
    if (active && src != 4'hF && src == dM) r = m;
    else if (active && src != 4'hF && src == dE) r = e;
`endif
    if (active && dE == 4'hE && dM == 4'hE) r = r; // keep both args referenced in default build
    return r;
  endfunction

  // Apply one cycle of inputs, check reads before the edge and halted after it
  task automatic drive(input bit r, input logic [3:0] ic, input logic [3:0] a,
                       input logic [3:0] b, input logic c, input logic [63:0] e,
                       input logic [63:0] m, input string tag,
                       output logic [63:0] obsA, output logic [63:0] obsB);
    logic [3:0]  sA, sB, dE, dM;
    logic [63:0] eA, eB;
    bit          active;
    rst = r; icode = ic; rA = a; rB = b; Cnd = c; valE = e; valM = m;
    #1;
    sA = expSrcA(ic, a);
    sB = expSrcB(ic, b);
    dE = expDstE(ic, b, c);
    dM = expDstM(ic, a);
    active = !r && !mHalted && ic >= 4'd1 && ic <= 4'd11;
    eA = expRead(sA, active, dE, dM, e, m);
    eB = expRead(sB, active, dE, dM, e, m);
    checks += 3;
    if (valA !== eA) begin
      failures++;
      $display("FAIL %s valA: got %h expected %h", tag, valA, eA);
    end
    if (valB !== eB) begin
      failures++;
      $display("FAIL %s valB: got %h expected %h", tag, valB, eB);
    end
    if (inv_instr !== (ic > 4'd11)) begin
      failures++;
      $display("FAIL %s inv_instr: got %b expected %b", tag, inv_instr, ic > 4'd11);
    end
    obsA = valA;
    obsB = valB;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 15; i++) model[i] = 64'h0;
      mHalted = 1'b0;
    end else if (!mHalted) begin
      if (ic == 4'd0) begin
        mHalted = 1'b1;
      end else if (active) begin
        if (dE != 4'hF) model[dE] = e;
        if (dM != 4'hF) model[dM] = m;
      end
    end
    #1;
    checks++;
    if (halted !== mHalted) begin
      failures++;
      $display("FAIL %s halted: got %b expected %b", tag, halted, mHalted);
    end
    $display("txn %-8s rst=%0b icode=%0d rA=%0d rB=%0d Cnd=%0b valA=%h valB=%h halted=%0b",
             tag, r, ic, a, b, c, obsA, obsB, halted);
  endtask

  task automatic test_reset();
    logic [63:0] oA, oB;
    drive(1'b1, 4'd1, 4'd0, 4'd0, 1'b0, 64'h0, 64'h0, "reset", oA, oB);
    drive(1'b0, 4'd6, 4'd0, 4'd3, 1'b0, 64'h0, 64'h0, "rst_rd", oA, oB);
    checks += 3;
    if (oA !== 64'h0) begin failures++; $display("FAIL reset_valA: got %h expected 0", oA); end
    if (oB !== 64'h0) begin failures++; $display("FAIL reset_valB: got %h expected 0", oB); end
    if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted: got %b expected 0", halted); end
  endtask

  task automatic test_irmovq();
    logic [63:0] oA, oB;
    drive(1'b0, 4'd3, 4'hF, 4'd2, 1'b0, 64'h1234, 64'h0, "irmovq", oA, oB);
    drive(1'b0, 4'd6, 4'd2, 4'd9, 1'b0, 64'h0, 64'h0, "opq_rd", oA, oB);
    checks++;
    if (oA !== 64'h1234) begin failures++; $display("FAIL irmovq_read: got %h expected 1234", oA); end
  endtask

  task automatic test_cmov();
    logic [63:0] oA, oB;
    drive(1'b0, 4'd2, 4'd1, 4'd5, 1'b0, 64'hAA, 64'h0, "cmov_n", oA, oB);
    drive(1'b0, 4'd4, 4'd5, 4'd5, 1'b0, 64'h0, 64'h0, "rd_r5", oA, oB);
    checks++;
    if (oA !== 64'h0) begin failures++; $display("FAIL cmov_cnd0: got %h expected 0", oA); end
    drive(1'b0, 4'd2, 4'd1, 4'd5, 1'b1, 64'hAA, 64'h0, "cmov_y", oA, oB);
    drive(1'b0, 4'd4, 4'd5, 4'd5, 1'b0, 64'h0, 64'h0, "rd_r5", oA, oB);
    checks++;
    if (oA !== 64'hAA) begin failures++; $display("FAIL cmov_cnd1: got %h expected aa", oA); end
  endtask

  task automatic test_popq();
    logic [63:0] oA, oB;
    drive(1'b0, 4'd11, 4'd4, 4'hF, 1'b0, 64'h108, 64'h55, "popq_sp", oA, oB);
    drive(1'b0, 4'd9, 4'hF, 4'hF, 1'b0, 64'h110, 64'h0, "ret", oA, oB);
    checks += 2;
    if (oA !== 64'h55) begin failures++; $display("FAIL popq_valA: got %h expected 55", oA); end
    if (oB !== 64'h55) begin failures++; $display("FAIL popq_valB: got %h expected 55", oB); end
  endtask

  task automatic test_halt();
    logic [63:0] oA, oB;
    drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 64'h0, 64'h0, "halt", oA, oB);
    checks++;
    if (halted !== 1'b1) begin failures++; $display("FAIL halt_set: got %b expected 1", halted); end
    drive(1'b0, 4'd3, 4'hF, 4'd7, 1'b0, 64'h9, 64'h0, "irm_hlt", oA, oB);
    drive(1'b0, 4'd4, 4'd7, 4'd7, 1'b0, 64'h0, 64'h0, "rd_r7", oA, oB);
    checks++;
    if (oA !== 64'h0) begin failures++; $display("FAIL halt_nowrite: got %h expected 0", oA); end
    drive(1'b1, 4'd1, 4'd0, 4'd0, 1'b0, 64'h0, 64'h0, "reset", oA, oB);
    checks++;
    if (halted !== 1'b0) begin failures++; $display("FAIL halt_clear: got %b expected 0", halted); end
  endtask

  task automatic test_invalid();
    logic [63:0] oA, oB;
    drive(1'b0, 4'd12, 4'd1, 4'd1, 1'b1, 64'hDEAD, 64'hBEEF, "invalid", oA, oB);
    for (int i = 0; i < 15; i += 2) begin
      drive(1'b0, 4'd4, 4'(i), 4'(i + 1), 1'b0, 64'h0, 64'h0, "scan", oA, oB);
    end
    drive(1'b0, 4'd4, 4'd1, 4'd1, 1'b0, 64'h0, 64'h0, "rd_r1", oA, oB);
    checks++;
    if (oA !== 64'h0) begin failures++; $display("FAIL invalid_nowrite: got %h expected 0", oA); end
  endtask

  task automatic test_bypass();
    logic [63:0] oA, oB;
    drive(1'b0, 4'd6, 4'd6, 4'd6, 1'b0, 64'h77, 64'h0, "opq_r6", oA, oB);
    checks += 2;
`ifdef WB_BYPASS_EN
    if (oA !== 64'h77) begin failures++; $display("FAIL bypass_valA: got %h expected 77", oA); end
    if (oB !== 64'h77) begin failures++; $display("FAIL bypass_valB: got %h expected 77", oB); end
`else
    if (oA !== 64'h0) begin failures++; $display("FAIL nobypass_valA: got %h expected 0", oA); end
    if (oB !== 64'h0) begin failures++; $display("FAIL nobypass_valB: got %h expected 0", oB); end
`endif
    drive(1'b0, 4'd4, 4'd6, 4'd6, 1'b0, 64'h0, 64'h0, "rd_r6", oA, oB);
    checks++;
    if (oA !== 64'h77) begin failures++; $display("FAIL r6_after_edge: got %h expected 77", oA); end
  endtask

  task automatic test_random();
    logic [63:0] oA, oB;
    logic [3:0]  ic;
    bit          r;
    for (int n = 0; n < 400; n++) begin
      ic = 4'($urandom_range(0, 15));
      if (ic == 4'd0 && $urandom_range(0, 3) != 0) ic = 4'd6;
      r = ($urandom_range(0, 19) == 0);
      drive(r, ic, 4'($urandom), 4'($urandom), 1'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, "random", oA, oB);
    end
  endtask

  initial begin
    for (int i = 0; i < 15; i++) model[i] = 64'h0;
    mHalted = 1'b0;
    rst = 1'b1; icode = 4'd1; rA = 4'd0; rB = 4'd0; Cnd = 1'b0;
    valE = 64'h0; valM = 64'h0;
    test_reset();
    test_irmovq();
    test_cmov();
    test_popq();
    test_halt();
    test_invalid();
    test_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
